regfile_operand_stage: RTL and testbench

//   Operand-fetch stage directly upstream of the 16-bit ALU ops: holds the 8x16 register file
//   and drives registered RS/RT operands into the ALU one cycle after an accepted read.
//   A per-register busy scoreboard, reserved at issue and cleared at writeback, blocks
//   RAW/WAW hazards by asserting STALL. Writeback from the ALU result path returns through
//   the WB port.

---
 rtl/mips16_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 45 ++++
 rtl/regfile_operand_stage.sv | 70 +++++++
 tb/tb_regfile_operand_stage.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// mips16_pkg: shared widths and types for the MIPS16 datapath blocks
package mips16_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, hazard detection and issue stall
//   Ports: i_clk, i_rst_n (async active-low); i_rd_en, i_rs_addr, i_rt_addr issue request;
//   i_rsv_en, i_rsv_addr destination reservation; i_wb_en, i_wb_addr writeback release;
//   o_stall combinational issue refusal; o_busy scoreboard bits.
//   Macro REGFILE_BYPASS_EN: a same-cycle writeback clears the RAW hazard on its register.
module regfile_scoreboard
    import mips16_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rd_en,
    input  reg_addr_t           i_rs_addr,
    input  reg_addr_t           i_rt_addr,
    input  logic                i_rsv_en,
    input  reg_addr_t           i_rsv_addr,
    input  logic                i_wb_en,
    input  reg_addr_t           i_wb_addr,
    output logic                o_stall,
    output logic [NUM_REGS-1:0] o_busy
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic                w_hz_s;
    logic                w_hz_t;
    logic                w_accept;
`ifdef REGFILE_BYPASS_EN
    assign w_hz_s = r_busy[i_rs_addr] & ~(i_wb_en & (i_wb_addr == i_rs_addr));
    assign w_hz_t = r_busy[i_rt_addr] & ~(i_wb_en & (i_wb_addr == i_rt_addr));
`else
    assign w_hz_s = r_busy[i_rs_addr];
    assign w_hz_t = r_busy[i_rt_addr];
`endif
    // WAW check is never bypassed: the destination must be fully released first
    assign o_stall  = i_rd_en & (w_hz_s | w_hz_t | (i_rsv_en & r_busy[i_rsv_addr]));
    assign w_accept = i_rd_en & ~o_stall;
    // R0 is never reserved, so BUSY[0] stays clear
    assign w_set = (w_accept & i_rsv_en & (i_rsv_addr != '0)) ? NUM_REGS'(1) << i_rsv_addr : '0;
    assign w_clr = i_wb_en ? NUM_REGS'(1) << i_wb_addr : '0;
    assign o_busy = r_busy;
    // set applied after clear so a same-edge reservation wins
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_busy <= '0;
        else          r_busy <= (r_busy & ~w_clr) | w_set;
endmodule

// File: rtl/regfile_operand_stage.sv
// regfile_operand_stage: 8x16 register file with registered operand fetch and hazard stall
//   Ports: i_clk, i_rst_n (async active-low); i_rd_en, i_rs_addr, i_rt_addr issue;
//   i_rsv_en, i_rsv_addr destination reservation; o_stall issue refused;
//   o_rs, o_rt, o_rd_valid registered operands; i_wb_en, i_wb_addr, i_wb_data writeback;
//   o_busy scoreboard bits.
//   Macro REGFILE_BYPASS_EN: same-cycle writeback data forwarded into operand capture.
module regfile_operand_stage
    import mips16_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rd_en,
    input  reg_addr_t           i_rs_addr,
    input  reg_addr_t           i_rt_addr,
    input  logic                i_rsv_en,
    input  reg_addr_t           i_rsv_addr,
    output logic                o_stall,
    output word_t               o_rs,
    output word_t               o_rt,
    output logic                o_rd_valid,
    input  logic                i_wb_en,
    input  reg_addr_t           i_wb_addr,
    input  word_t               i_wb_data,
    output logic [NUM_REGS-1:0] o_busy
);
    word_t r_regs [NUM_REGS];
    word_t w_rs_data;
    word_t w_rt_data;
    logic  w_accept;
    regfile_scoreboard u_sb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_en    (i_rd_en),
        .i_rs_addr  (i_rs_addr),
        .i_rt_addr  (i_rt_addr),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_addr (i_rsv_addr),
        .i_wb_en    (i_wb_en),
        .i_wb_addr  (i_wb_addr),
        .o_stall    (o_stall),
        .o_busy     (o_busy)
    );
    assign w_accept = i_rd_en & ~o_stall;
`ifdef REGFILE_BYPASS_EN
    assign w_rs_data = (i_wb_en && i_wb_addr == i_rs_addr && i_rs_addr != '0) ? i_wb_data : r_regs[i_rs_addr];
    assign w_rt_data = (i_wb_en && i_wb_addr == i_rt_addr && i_rt_addr != '0) ? i_wb_data : r_regs[i_rt_addr];
`else
    assign w_rs_data = r_regs[i_rs_addr];
    assign w_rt_data = r_regs[i_rt_addr];
`endif
    // R0 is never written, so it reads zero from the array
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_wb_en && i_wb_addr != '0) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            o_rs       <= '0;
            o_rt       <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= w_accept;
            if (w_accept) begin
                o_rs <= w_rs_data;
                o_rt <= w_rt_data;
            end
        end
endmodule

// File: tb/tb_regfile_operand_stage.sv
// tb_regfile_operand_stage: scoreboard-driven self-checking bench for the operand stage
module tb_regfile_operand_stage;
    import mips16_pkg::*;
    typedef struct packed { word_t rs; word_t rt; } ops_t;
    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                rd_en = 1'b0, rsv_en = 1'b0, wb_en = 1'b0;
    reg_addr_t           rs_addr = '0, rt_addr = '0, rsv_addr = '0, wb_addr = '0;
    word_t               wb_data = '0;
    logic                stall, rd_valid;
    word_t               rs, rt;
    logic [NUM_REGS-1:0] busy;
    word_t               m_regs [NUM_REGS];
    logic [NUM_REGS-1:0] m_busy;
    ops_t                exp_q [$];
    int                  n_checks = 0, n_errors = 0;
    regfile_operand_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_rs_addr(rs_addr), .i_rt_addr(rt_addr),
        .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_stall(stall), .o_rs(rs), .o_rt(rt),
        .o_rd_valid(rd_valid), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic hz(input reg_addr_t a);
`ifdef REGFILE_BYPASS_EN
        return m_busy[a] && !(wb_en && wb_addr == a);
`else
        return m_busy[a];
`endif
    endfunction
    function automatic word_t rd_val(input reg_addr_t a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return m_regs[a];
    endfunction
    function automatic logic [NUM_REGS-1:0] onehot(input reg_addr_t a);
        logic [NUM_REGS-1:0] v = '0;
        v[a] = 1'b1;
        return v;
    endfunction
    // one clock: drive at negedge, check stall, push expectation, check outputs after the edge
    task automatic cycle(input logic rd, input reg_addr_t s, input reg_addr_t t, input logic rsv,
                         input reg_addr_t ra, input logic wb, input reg_addr_t wa, input word_t wd);
        logic e_stall, acc;
        ops_t o;
        rd_en = rd; rs_addr = s; rt_addr = t; rsv_en = rsv; rsv_addr = ra;
        wb_en = wb; wb_addr = wa; wb_data = wd;
        #1;
        e_stall = rd && (hz(s) || hz(t) || (rsv && m_busy[ra]));
        check("stall", stall, e_stall);
        acc = rd && !e_stall;
        if (acc) exp_q.push_back('{rs: rd_val(s), rt: rd_val(t)});
        @(posedge clk);
        if (wb) begin
            if (wa != 0) m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (acc && rsv && ra != 0) m_busy[ra] = 1'b1;
        #1;
        check("rd_valid", rd_valid, acc);
        if (acc && exp_q.size() > 0) begin
            o = exp_q.pop_front();
            check("rs", rs, o.rs);
            check("rt", rt, o.rt);
        end
        check("busy", busy, m_busy);
        @(negedge clk);
    endtask
    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        m_busy = '0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        #1;
        check("rst_rs", rs, 0);
        check("rst_rt", rt, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // write then read R3 with R0
        cycle(0, 0, 0, 0, 0, 1, 3, 16'h00FF);
        cycle(1, 3, 0, 0, 0, 0, 0, 0);
        check("t2_rs", rs, 16'h00FF);
        idle();
        check("t2_hold", rs, 16'h00FF);
        // RAW on a reserved R5
        cycle(1, 1, 2, 1, 5, 0, 0, 0);
        check("t3_busy5", busy, onehot(5));
        cycle(1, 5, 0, 0, 0, 0, 0, 0);
        cycle(1, 5, 0, 0, 0, 0, 0, 0);
        cycle(1, 5, 0, 0, 0, 1, 5, 16'h1234);
`ifdef REGFILE_BYPASS_EN
        check("t3_byp_rs", rs, 16'h1234);
`endif
        cycle(1, 5, 0, 0, 0, 0, 0, 0);
        check("t3_rs", rs, 16'h1234);
        // R0 writes and reservations ignored
        cycle(1, 0, 0, 1, 0, 1, 0, 16'hFFFF);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("t4_r0", rs, 0);
        check("t4_busy0", busy[0], 0);
        // same-edge reserve and writeback of R2
        cycle(1, 1, 1, 1, 2, 1, 2, 16'hBEEF);
        check("t5_busy2", busy[2], 1);
        cycle(0, 0, 0, 0, 0, 1, 2, 16'h2222);
        // WAW on R4
        cycle(1, 1, 1, 1, 4, 0, 0, 0);
        cycle(1, 1, 1, 1, 4, 0, 0, 0);
        check("t6_busy", busy, onehot(4));
        cycle(1, 1, 1, 1, 4, 1, 4, 16'h4444);
        cycle(1, 4, 1, 1, 4, 0, 0, 0);
        check("t6_rs", rs, 16'h4444);
        cycle(0, 0, 0, 0, 0, 1, 4, 16'h4040);
        // random traffic against the model
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 1), 3'($urandom), 3'($urandom), $urandom_range(0, 1), 3'($urandom),
                  $urandom_range(0, 2) == 0, 3'($urandom), 16'($urandom));
        // asynchronous reset in the middle of an issue
        cycle(0, 0, 0, 0, 0, 1, 6, 16'h6666);
        cycle(1, 6, 6, 1, 7, 0, 0, 0);
        rd_en = 1'b1; rs_addr = 3'd6; rt_addr = 3'd6; rsv_en = 1'b1; rsv_addr = 3'd1; wb_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rs", rs, 0);
        check("mid_rst_rt", rt, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_stall", stall, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
